prio_encoder_rr: RTL
====================

Name: prio_encoder_rr

Overview:
- Parametrised, registered successor of the team's 8-to-3 priority encoder. Keeps its EI/GS/EO semantics.
- Adds three things:
  - N-wide input, with N a parameter.
  - Runtime choice of fixed-priority or round-robin arbitration.
  - A registered output stage with a valid/ready handshake.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that accepts one encoded winner per handshake.

Parameters:
- N, 8, number of request inputs (2..64).
- W, 3, encoded index width; must satisfy 2**W >= N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- EI  input  1  enable input; 0 suppresses all encoding.
- I  input  N  request vector.
- out_ready  input  1  consumer accepts the current result.
- Y  output  W  registered encoded winner index.
- grant  output  N  registered one-hot winner; all zero when GS=0.
- GS  output  1  registered "group select": result valid, at least one request won.
- EO  output  1  registered enable output: EI=1 and I all zero.

Behaviour:
- Reset (async, immediate, also mid-stall): Y=0, grant=0, GS=0, EO=0, internal pointer ptr=N-1.
- Load condition: load = !GS || out_ready.
  - When load=1, sample EI, I and mode, and register the result at the next rising edge. Latency is 1 cycle.
  - When load=0 (stall: GS=1 && out_ready=0), Y, grant, GS, EO and ptr all hold. Inputs, including mode, are ignored.
- Combinational result from the sampled EI, I and mode:
  - EI=0 → Y=0, grant=0, GS=0, EO=0.
  - EI=1, I=0 → Y=0, grant=0, GS=0, EO=1.
  - EI=1, I!=0, mode=0 → k = highest set index; Y=k, grant=1<<k, GS=1, EO=0.
  - EI=1, I!=0, mode=1 → search order is ptr, ptr-1, …, 0, N-1, …, ptr+1. k = first set bit in that order. Y=k, grant=1<<k, GS=1, EO=0.
- EO and GS are never both 1.
- EO is a status-only output: it does not take part in the handshake and is re-evaluated every load cycle.
- Pointer update:
  - On a handshake (GS=1 && out_ready=1) while the held result was produced in mode=1: ptr <= (Y==0) ? N-1 : Y-1. The previous winner thereby becomes lowest priority.
  - In mode=0, ptr is untouched.
  - Switching mode retains ptr.
  - After reset, round-robin behaves identically to fixed priority until the first round-robin handshake.
- Wrap-around: ptr decrements modulo N, never modulo 2**W. When N < 2**W, indices ≥ N are never produced.
- Back-to-back: with out_ready held 1, a new result loads every cycle. Throughput is 1 per clock.
- A request dropping during a stall does not retract the held result.
- Simultaneous handshake and new sample: the ptr update and the new-result computation use the pre-update ptr? No — the new result loaded in the handshake cycle uses the **updated** ptr value. Implementation must compute next-ptr combinationally from the held Y and feed it to the search.

Test Plan:
1. Reset, then mode=0, EI=1, I=8'b0010_1100, out_ready=1 → one cycle later Y=5, grant=8'h20, GS=1, EO=0. Next: EI=0 → Y=0, GS=0, EO=0. Next: EI=1, I=0 → GS=0, EO=1.
2. mode=1, N=8, I=8'hFF held, out_ready=1 for 9 cycles → Y sequence 7,6,5,4,3,2,1,0,7, each with the matching one-hot grant.
3. mode=1, I=8'b1000_0001, out_ready=1 → Y alternates 7,0,7,0.
4. Stall: result Y=5, GS=1 with out_ready=0 for 4 cycles while I changes to 8'h02 and mode toggles → Y=5, GS=1 and ptr are stable throughout. Release out_ready → held result is consumed, then Y=1 on the next cycle.
5. Assert rst during a stall with Y=3, GS=1 → outputs go to zero immediately without a clock edge. After release, mode=1 with I=8'hFF → Y=7 (ptr back to N-1).
6. N=5, W=3, mode=1, I=5'b11111 for 6 handshakes → Y = 4,3,2,1,0,4; no Y value ≥ 5 is ever produced.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// prio_encoder_rr_if: request-side inputs and registered winner outputs of the priority encoder
interface prio_encoder_rr_if #(parameter int N = 8, parameter int W = 3);
    logic         mode;
    logic         EI;
    logic [N-1:0] I;
    logic         out_ready;
    logic [W-1:0] Y;
    logic [N-1:0] grant;
    logic         GS;
    logic         EO;
    modport master (output mode, EI, I, out_ready, input Y, grant, GS, EO);
    modport slave  (input mode, EI, I, out_ready, output Y, grant, GS, EO);
endinterface

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-input fixed/round-robin priority encoder with registered valid/ready output
module prio_encoder_rr #(parameter int N = 8, parameter int W = 3) (
    input logic           clk,
    input logic           rst,
    prio_encoder_rr_if.slave b
);
    logic [W-1:0] ptr, pn, ny;
    logic [N-1:0] lo, ng;
    logic         rmode, load, hs, ngs, neo;

    function automatic logic [W-1:0] hi(input logic [N-1:0] v);
        hi = '0;
        for (int i = 0; i < N; i++) if (v[i]) hi = W'(i);
    endfunction

    // pointer advanced past the winner being consumed now, then split search: ptr..0 first, else wrap from N-1
    always_comb begin
        load = !b.GS || b.out_ready;
        hs = b.GS && b.out_ready;
        pn = (hs && rmode) ? ((b.Y == '0) ? W'(N - 1) : b.Y - W'(1)) : ptr;
        lo = '0;
        for (int i = 0; i < N; i++) lo[i] = W'(i) <= pn;
        ngs = b.EI && |b.I;
        neo = b.EI && !(|b.I);
        ny = !ngs ? '0 : (b.mode && |(b.I & lo)) ? hi(b.I & lo) : hi(b.I);
        ng = ngs ? N'(1) << ny : '0;
    end

    // output stage and pointer; everything holds while a valid result waits for the consumer
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            b.Y <= '0;
            b.grant <= '0;
            b.GS <= 1'b0;
            b.EO <= 1'b0;
            ptr <= W'(N - 1);
            rmode <= 1'b0;
        end else if (load) begin
            b.Y <= ny;
            b.grant <= ng;
            b.GS <= ngs;
            b.EO <= neo;
            ptr <= pn;
            rmode <= b.mode;
        end
endmodule
